// File: rtl/noise_cdf_loader.sv
// Streams 128 PMF weights into a running CDF and writes it into the noise generator's table.
// Optional macro NOISE_CDF_LOADER_SAT_EN: saturate the CDF at all-ones instead of wrapping.
module noise_cdf_loader #(
  parameter int NUM_BINS    = 128,
  parameter int DATA_W      = 64,
  parameter int TAIL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] pmf_data,
  input  logic              pmf_valid,
  output logic              pmf_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic [7:0]        location,
  output logic              load_mem,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        entry_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    TAIL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_BINS - 1);
  localparam logic [7:0] TAIL_LEN = 8'(TAIL_CYCLES);

  state_t            state_r, state_s;
  logic [DATA_W-1:0] acc_r, acc_s;
  logic [DATA_W-1:0] mem_data_r, mem_data_s;
  logic [7:0]        index_r, index_s;
  logic [7:0]        location_r, location_s;
  logic [7:0]        entry_count_r, entry_count_s;
  logic [7:0]        tail_cnt_r, tail_cnt_s;
  logic              load_mem_r, load_mem_s;
  logic              overflow_r, overflow_s;
  logic              xfer_s;
  logic [DATA_W:0]   add_s;

  // Top bit is the carry out; the low DATA_W bits are the next CDF value.
  function automatic logic [DATA_W:0] cdf_add(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`ifdef NOISE_CDF_LOADER_SAT_EN
    if (sum[DATA_W]) begin
      sum = {1'b1, {DATA_W{1'b1}}};
    end else begin
      sum = sum;
    end
`endif
    return sum;
  endfunction

  assign pmf_ready   = (state_r == ACCUM);
  assign busy        = (state_r == ACCUM) || (state_r == TAIL);
  assign done        = (state_r == DONE);
  assign mem_data    = mem_data_r;
  assign location    = location_r;
  assign load_mem    = load_mem_r;
  assign overflow    = overflow_r;
  assign entry_count = entry_count_r;

  assign xfer_s = pmf_valid && (state_r == ACCUM);
  assign add_s  = cdf_add(acc_r, pmf_data);

  // Next-state and next-output decode.
  always_comb begin
    state_s       = state_r;
    acc_s         = acc_r;
    mem_data_s    = mem_data_r;
    index_s       = index_r;
    location_s    = location_r;
    entry_count_s = entry_count_r;
    tail_cnt_s    = tail_cnt_r;
    load_mem_s    = 1'b0;
    overflow_s    = overflow_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s       = ACCUM;
          acc_s         = {DATA_W{1'b0}};
          index_s       = 8'd0;
          entry_count_s = 8'd0;
          overflow_s    = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ACCUM: begin
        if (xfer_s) begin
          acc_s         = add_s[DATA_W-1:0];
          mem_data_s    = add_s[DATA_W-1:0];
          location_s    = index_r;
          load_mem_s    = 1'b1;
          index_s       = index_r + 8'd1;
          entry_count_s = entry_count_r + 8'd1;
          overflow_s    = overflow_r | add_s[DATA_W];
          tail_cnt_s    = 8'd0;
          if (index_r == LAST_IDX) begin
            state_s = TAIL;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      // First TAIL cycle shows the last entry's strobe; TAIL_LEN more strobes follow.
      TAIL: begin
        if (tail_cnt_r == TAIL_LEN) begin
          state_s = DONE;
        end else begin
          load_mem_s = 1'b1;
          tail_cnt_s = tail_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= IDLE;
      acc_r         <= {DATA_W{1'b0}};
      mem_data_r    <= {DATA_W{1'b0}};
      index_r       <= 8'd0;
      location_r    <= 8'd0;
      entry_count_r <= 8'd0;
      tail_cnt_r    <= 8'd0;
      load_mem_r    <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      acc_r         <= acc_s;
      mem_data_r    <= mem_data_s;
      index_r       <= index_s;
      location_r    <= location_s;
      entry_count_r <= entry_count_s;
      tail_cnt_r    <= tail_cnt_s;
      load_mem_r    <= load_mem_s;
      overflow_r    <= overflow_s;
    end
  end

endmodule

// File: tb/tb_noise_cdf_loader.sv
// Randomised bench for noise_cdf_loader against an arithmetic CDF reference model.
module tb_noise_cdf_loader;
  localparam int NB = 128;
  localparam int DW = 64;
  localparam int TC = 1;
  localparam int BUDGET = 4000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] pmf_data = '0;
  logic          pmf_valid = 1'b0;
  logic          pmf_ready;
  logic [DW-1:0] mem_data;
  logic [7:0]    location;
  logic          load_mem;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [7:0]    entry_count;

  noise_cdf_loader #(.NUM_BINS(NB), .DATA_W(DW), .TAIL_CYCLES(TC)) dut (
    .clk(clk), .rstn(rstn), .start(start), .pmf_data(pmf_data), .pmf_valid(pmf_valid),
    .pmf_ready(pmf_ready), .mem_data(mem_data), .location(location), .load_mem(load_mem),
    .busy(busy), .done(done), .overflow(overflow), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] w [NB];
  logic [DW-1:0] exp_cdf [NB];
  logic          exp_ovf;
  logic [DW-1:0] cap_data [$];
  logic [7:0]    cap_loc [$];
  logic          xfer_d = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) xfer_d <= pmf_valid && pmf_ready;

  // While accepting, a strobe must appear exactly one cycle after each transfer.
  always @(negedge clk) begin
    if (rstn) begin
      if (load_mem) begin
        cap_data.push_back(mem_data);
        cap_loc.push_back(location);
      end
      if (pmf_ready) check_eq("strobe_vs_xfer", {63'd0, load_mem}, {63'd0, xfer_d});
      if (busy) check_eq("done_while_busy", {63'd0, done}, 64'd0);
    end
  end

  task automatic build_model();
    logic [DW-1:0] acc, t;
    acc = '0;
    exp_ovf = 1'b0;
    for (int i = 0; i < NB; i++) begin
      t = acc + w[i];
      if (t < acc) begin
        exp_ovf = 1'b1;
`ifdef NOISE_CDF_LOADER_SAT_EN
        t = '1;
`endif
      end
      acc = t;
      exp_cdf[i] = acc;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_mem_data"}, mem_data, 64'd0);
    check_eq({tag, "_outs"}, {56'd0, location}, 64'd0);
    check_eq({tag, "_flags"}, {58'd0, pmf_ready, load_mem, busy, done, overflow, 1'b0}, 64'd0);
    check_eq({tag, "_count"}, {56'd0, entry_count}, 64'd0);
  endtask

  // vmode 0: valid always, 1: alternating, 2: random ~75%.
  task automatic drive_load(input int vmode, input int start_at, input int reset_at,
                            output bit aborted);
    int i;
    int cyc;
    bit rdy;
    bit sent;
    i = 0; cyc = 0; sent = 0; aborted = 0;
    cap_data.delete();
    cap_loc.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("busy_after_start", {62'd0, busy, done}, 64'd2);
    check_eq("count_cleared", {56'd0, entry_count}, 64'd0);
    while (i < NB && cyc < BUDGET) begin
      if (i == reset_at) begin
        rstn = 1'b0;
        pmf_valid = 1'b0;
        aborted = 1;
        #1;
        break;
      end
      pmf_data = w[i];
      case (vmode)
        0: pmf_valid = 1'b1;
        1: pmf_valid = (cyc % 2 == 0);
        default: pmf_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (i == start_at && !sent) begin
        start = 1'b1;
        sent = 1;
      end else begin
        start = 1'b0;
      end
      rdy = pmf_ready;
      @(posedge clk); #1;
      if (pmf_valid && rdy) i++;
      cyc++;
    end
    pmf_valid = 1'b0;
    start = 1'b0;
    check_eq("drive_budget", {63'd0, cyc < BUDGET}, 64'd1);
  endtask

  task automatic finish_and_verify(input string tag);
    int k;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq({tag, "_done"}, {63'd0, done}, 64'd1);
    check_eq({tag, "_n_strobe"}, 64'(cap_data.size()), 64'(NB + TC));
    for (int j = 0; j < cap_data.size() && j < NB + TC; j++) begin
      int e;
      e = (j < NB) ? j : NB - 1;
      check_eq($sformatf("%s_loc%0d", tag, j), {56'd0, cap_loc[j]}, 64'(e));
      check_eq($sformatf("%s_cdf%0d", tag, j), cap_data[j], exp_cdf[e]);
    end
    check_eq({tag, "_ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
    check_eq({tag, "_entries"}, {56'd0, entry_count}, 64'(NB));
    check_eq({tag, "_quiet"}, {61'd0, busy, pmf_ready, load_mem}, 64'd0);
    check_eq({tag, "_final"}, mem_data, exp_cdf[NB-1]);
  endtask

  initial begin
    bit ab;
    #1;
    check_idle_zero("reset");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_idle_zero("idle");

    // Uniform PMF that sums to exactly 2^64: last entry wraps to zero.
    for (int i = 0; i < NB; i++) w[i] = 64'h0200_0000_0000_0000;
    build_model();
    drive_load(0, -1, -1, ab);
    finish_and_verify("uniform");
    check_eq("uniform_first", exp_cdf[0], 64'h0200_0000_0000_0000);

    // Reload from DONE with all-ones weights clears overflow.
    for (int i = 0; i < NB; i++) w[i] = 64'd1;
    build_model();
    drive_load(2, -1, -1, ab);
    finish_and_verify("reload");
    check_eq("reload_end", mem_data, 64'd128);

    // Gapped valid with weights 1,2,3,...; start coinciding with the last word is ignored.
    for (int i = 0; i < NB; i++) w[i] = 64'(i + 1);
    build_model();
    drive_load(1, NB - 1, -1, ab);
    finish_and_verify("gaps");

    // Random weights, start pulse mid-load.
    for (int i = 0; i < NB; i++) w[i] = {$urandom, $urandom} >> $urandom_range(0, 8);
    build_model();
    drive_load(2, 50, -1, ab);
    finish_and_verify("start_busy");

    // Reset at entry 70, then a clean reload.
    drive_load(0, -1, 70, ab);
    check_eq("aborted", {63'd0, ab}, 64'd1);
    check_idle_zero("midreset");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle_zero("post_reset");
    for (int i = 0; i < NB; i++) w[i] = {32'd0, $urandom};
    build_model();
    drive_load(2, -1, -1, ab);
    finish_and_verify("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
